// File: rtl/spram_lane_bank.sv
// Single-port byte-lane RAM: zero-fills itself after reset, then serves one read or write per cycle.
// Latency: writes commit at the accepting edge; read data arrives READ_LAT cycles after acceptance.
// Backpressure: READY is low during the post-reset zero-fill, then stays high; nothing stalls once idle.
module spram_lane_bank #(
    parameter int LANES    = 2,
    parameter int AW       = 8,
    parameter int READ_LAT = 1
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic                 CS,
    input  logic                 RD,
    input  logic                 WR,
    input  logic [LANES-1:0]     BE,
    input  logic [AW-1:0]        AD,
    input  logic [8*LANES-1:0]   DI,
    output logic [8*LANES-1:0]   DO,
    output logic                 READY,
    output logic                 DVALID,
    output logic                 ERR
);

    localparam int DW = 8 * LANES;
    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t          state;
    logic [AW-1:0]   init_cnt;
    logic            ready_q;
    logic            err_q;

    logic [DW-1:0]   mem [2**AW];
    logic [DW-1:0]   wr_word;
    logic            rd_acc;
    logic            wr_acc;

    logic [READ_LAT-1:0] pipe_vld;
    logic [DW-1:0]       pipe_dat [READ_LAT];

    assign rd_acc = (state == S_IDLE) && CS && RD && !WR;
    assign wr_acc = (state == S_IDLE) && CS && WR && !RD;

    // Merge enabled lanes of DI over the current word so disabled lanes keep their contents.
    always_comb begin
        wr_word = mem[AD];
        for (int i = 0; i < LANES; i++) begin
            if (BE[i]) begin
                wr_word[8*i +: 8] = DI[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state    <= S_INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + CNT_ONE;
                    if (init_cnt == '1) begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    ready_q <= 1'b1;
                    err_q   <= CS && RD && WR;
                end
                default: begin
                    state   <= S_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is never reset; the NRST qualifier keeps the zero-fill from running while reset is held.
    always_ff @(posedge CLK) begin
        if (NRST && state == S_INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_acc) begin
            mem[AD] <= wr_word;
        end
    end

    // Each stage only reloads on a valid beat, so the final stage doubles as the DO hold register.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            pipe_vld <= '0;
            for (int k = 0; k < READ_LAT; k++) begin
                pipe_dat[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= mem[AD];
            end
            for (int k = 1; k < READ_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_dat[k] <= pipe_dat[k-1];
                end
            end
        end
    end

    assign DO     = pipe_dat[READ_LAT-1];
    assign DVALID = pipe_vld[READ_LAT-1];
    assign READY  = ready_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_spram_lane_bank.sv
// Four copies of the bank (READ_LAT 1..4) share one stimulus stream and are checked against a reference model.
module tb_spram_lane_bank;

    logic        CLK;
    logic        NRST;
    logic        CS, RD, WR;
    logic [1:0]  BE;
    logic [7:0]  AD;
    logic [15:0] DI;
    logic [15:0] do_w [4];
    logic [3:0]  ready_w, dvalid_w, err_w;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : g_lat
        spram_lane_bank #(.LANES(2), .AW(8), .READ_LAT(g + 1)) u_dut (
            .CLK(CLK), .NRST(NRST), .CS(CS), .RD(RD), .WR(WR), .BE(BE), .AD(AD), .DI(DI),
            .DO(do_w[g]), .READY(ready_w[g]), .DVALID(dvalid_w[g]), .ERR(err_w[g])
        );
    end

    typedef struct {
        bit          cs, rd, wr;
        logic [1:0]  be;
        logic [7:0]  ad;
        logic [15:0] di;
    } op_t;

    // Reference model: word array plus a history of accepted reads, one slot per clock edge.
    logic [15:0] model_mem [256];
    bit          m_ready;
    int          init_edges;
    bit          h_vld [8];
    logic [15:0] h_dat [8];
    int          cyc = 8;
    logic [3:0]  exp_dv;
    logic [15:0] exp_do [4];
    bit          exp_err;
    int          total = 0;
    int          bad = 0;

    function automatic op_t mk(bit cs, bit rd, bit wr, logic [1:0] be, logic [7:0] ad, logic [15:0] di);
        op_t o;
        o.cs = cs; o.rd = rd; o.wr = wr; o.be = be; o.ad = ad; o.di = di;
        return o;
    endfunction

    function automatic op_t rd_op(logic [7:0] ad);
        return mk(1, 1, 0, 2'b00, ad, 16'h0);
    endfunction

    function automatic op_t wr_op(logic [7:0] ad, logic [15:0] di, logic [1:0] be);
        return mk(1, 0, 1, be, ad, di);
    endfunction

    function automatic op_t idle_op();
        return mk(0, 0, 0, 2'b00, 8'h00, 16'h0);
    endfunction

    task automatic model_reset();
        m_ready    = 0;
        init_edges = 0;
        exp_dv     = '0;
        exp_err    = 0;
        for (int g = 0; g < 4; g++) exp_do[g] = '0;
        for (int s = 0; s < 8; s++) h_vld[s] = 0;
        for (int a = 0; a < 256; a++) model_mem[a] = '0;
    endtask

    // Drives one cycle of inputs, advances the clock and updates the model to match.
    task automatic step(input op_t o);
        int slot;
        int s;
        CS = o.cs; RD = o.rd; WR = o.wr; BE = o.be; AD = o.ad; DI = o.di;
        @(posedge CLK);
        cyc++;
        slot = cyc % 8;
        h_vld[slot] = 0;
        exp_err = 0;
        if (NRST) begin
            if (m_ready && o.cs) begin
                if (o.rd && o.wr) begin
                    exp_err = 1;
                end else if (o.rd) begin
                    h_vld[slot] = 1;
                    h_dat[slot] = model_mem[o.ad];
                end else if (o.wr) begin
                    for (int i = 0; i < 2; i++)
                        if (o.be[i]) model_mem[o.ad][8*i +: 8] = o.di[8*i +: 8];
                end
            end
            if (!m_ready) begin
                init_edges++;
                if (init_edges == 256) m_ready = 1;
            end
        end
        for (int g = 0; g < 4; g++) begin
            s = (cyc - g) % 8;
            exp_dv[g] = h_vld[s];
            if (h_vld[s]) exp_do[g] = h_dat[s];
        end
        #1;
    endtask

    task automatic test_reset();
        NRST = 1'b1; CS = 0; RD = 0; WR = 0; BE = '0; AD = '0; DI = '0;
        #2 NRST = 1'b0;
        model_reset();
        #1;
        total++; if (ready_w !== 4'h0) begin bad++; $display("FAIL reset ready: got %b want 0000", ready_w); end
        total++; if (dvalid_w !== 4'h0) begin bad++; $display("FAIL reset dvalid: got %b want 0000", dvalid_w); end
        total++; if (err_w !== 4'h0) begin bad++; $display("FAIL reset err: got %b want 0000", err_w); end
        for (int g = 0; g < 4; g++) begin
            total++; if (do_w[g] !== 16'h0) begin bad++; $display("FAIL reset do[lat%0d]: got %h want 0000", g + 1, do_w[g]); end
        end
        step(idle_op());
        step(idle_op());
        NRST = 1'b1;
        for (int i = 0; i < 258; i++) begin
            step(i == 100 ? rd_op(8'h01) : idle_op());
            total++; if (ready_w !== {4{m_ready}}) begin bad++; $display("FAIL init ready cyc %0d: got %b want %b", i, ready_w, {4{m_ready}}); end
            total++; if (dvalid_w !== exp_dv) begin bad++; $display("FAIL init dvalid cyc %0d: got %b want %b", i, dvalid_w, exp_dv); end
            total++; if (err_w !== {4{exp_err}}) begin bad++; $display("FAIL init err cyc %0d: got %b want %b", i, err_w, {4{exp_err}}); end
        end
    endtask

    task automatic test_init_zero();
        int pulses = 0;
        for (int a = 0; a < 260; a++) begin
            step(a < 256 ? rd_op(8'(a)) : idle_op());
            if (dvalid_w[1]) pulses++;
            total++; if (dvalid_w !== exp_dv) begin bad++; $display("FAIL zero dvalid %0d: got %b want %b", a, dvalid_w, exp_dv); end
            for (int g = 0; g < 4; g++) begin
                total++; if (do_w[g] !== exp_do[g]) begin bad++; $display("FAIL zero do[lat%0d] %0d: got %h want %h", g + 1, a, do_w[g], exp_do[g]); end
            end
        end
        total++; if (pulses !== 256) begin bad++; $display("FAIL zero pulse count: got %0d want 256", pulses); end
    endtask

    task automatic test_byte_enable();
        op_t ops[$];
        ops.push_back(wr_op(8'h10, 16'hABCD, 2'b11));
        ops.push_back(wr_op(8'h10, 16'h1234, 2'b01));
        ops.push_back(rd_op(8'h10));
        for (int i = 0; i < 4; i++) ops.push_back(idle_op());
        ops.push_back(wr_op(8'h10, 16'hFFFF, 2'b00));
        ops.push_back(rd_op(8'h10));
        for (int i = 0; i < 4; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            total++; if (dvalid_w !== exp_dv) begin bad++; $display("FAIL be dvalid %0d: got %b want %b", i, dvalid_w, exp_dv); end
            for (int g = 0; g < 4; g++) begin
                total++; if (do_w[g] !== exp_do[g]) begin bad++; $display("FAIL be do[lat%0d] %0d: got %h want %h", g + 1, i, do_w[g], exp_do[g]); end
            end
        end
        for (int g = 0; g < 4; g++) begin
            total++; if (do_w[g] !== 16'hAB34) begin bad++; $display("FAIL be final do[lat%0d]: got %h want ab34", g + 1, do_w[g]); end
        end
    endtask

    task automatic test_latency();
        op_t ops[$];
        ops.push_back(wr_op(8'h03, 16'h5A5A, 2'b11));
        ops.push_back(rd_op(8'h03));
        for (int i = 0; i < 4; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            for (int g = 0; g < 4; g++) begin
                total++;
                if (i >= 1 && dvalid_w[g] !== ((i - 1) == g)) begin
                    bad++; $display("FAIL lat dvalid[lat%0d] +%0d: got %b want %b", g + 1, i - 1, dvalid_w[g], (i - 1) == g);
                end
                if (i >= 1 && (i - 1) == g && do_w[g] !== 16'h5A5A) begin
                    bad++; $display("FAIL lat do[lat%0d]: got %h want 5a5a", g + 1, do_w[g]);
                end
                total++; if (do_w[g] !== exp_do[g]) begin bad++; $display("FAIL lat model do[lat%0d] %0d: got %h want %h", g + 1, i, do_w[g], exp_do[g]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops[$];
        logic [15:0] seen[$];
        logic [15:0] want [4];
        want[0] = 16'h1000; want[1] = 16'h1001; want[2] = 16'h1002; want[3] = 16'h5A5A;
        for (int a = 0; a < 3; a++) ops.push_back(wr_op(8'(a), 16'h1000 + 16'(a), 2'b11));
        for (int a = 0; a < 4; a++) ops.push_back(rd_op(8'(a)));
        for (int i = 0; i < 4; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            if (dvalid_w[3]) seen.push_back(do_w[3]);
            total++; if (dvalid_w !== exp_dv) begin bad++; $display("FAIL b2b dvalid %0d: got %b want %b", i, dvalid_w, exp_dv); end
            for (int g = 0; g < 4; g++) begin
                total++; if (do_w[g] !== exp_do[g]) begin bad++; $display("FAIL b2b do[lat%0d] %0d: got %h want %h", g + 1, i, do_w[g], exp_do[g]); end
            end
        end
        total++; if (seen.size() !== 4) begin bad++; $display("FAIL b2b pulse count: got %0d want 4", seen.size()); end
        for (int k = 0; k < 4 && k < seen.size(); k++) begin
            total++; if (seen[k] !== want[k]) begin bad++; $display("FAIL b2b order %0d: got %h want %h", k, seen[k], want[k]); end
        end
    endtask

    task automatic test_illegal();
        op_t ops[$];
        ops.push_back(wr_op(8'h05, 16'h0505, 2'b11));
        ops.push_back(mk(1, 1, 1, 2'b11, 8'h05, 16'hFFFF));
        ops.push_back(idle_op());
        ops.push_back(mk(0, 1, 1, 2'b11, 8'h05, 16'hFFFF));
        ops.push_back(idle_op());
        ops.push_back(rd_op(8'h05));
        for (int i = 0; i < 4; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            if (i == 1) begin
                total++; if (err_w !== 4'hF) begin bad++; $display("FAIL illegal err: got %b want 1111", err_w); end
            end
            if (i == 3 || i == 2) begin
                total++; if (err_w !== 4'h0) begin bad++; $display("FAIL illegal err after %0d: got %b want 0000", i, err_w); end
            end
            if (i >= 1 && i <= 4) begin
                total++; if (dvalid_w !== 4'h0) begin bad++; $display("FAIL illegal dvalid %0d: got %b want 0000", i, dvalid_w); end
            end
            total++; if (err_w !== {4{exp_err}}) begin bad++; $display("FAIL illegal model err %0d: got %b want %b", i, err_w, {4{exp_err}}); end
            total++; if (dvalid_w !== exp_dv) begin bad++; $display("FAIL illegal model dvalid %0d: got %b want %b", i, dvalid_w, exp_dv); end
        end
        for (int g = 0; g < 4; g++) begin
            total++; if (do_w[g] !== 16'h0505) begin bad++; $display("FAIL illegal mem5 do[lat%0d]: got %h want 0505", g + 1, do_w[g]); end
        end
    endtask

    task automatic test_hazard();
        op_t ops[$];
        ops.push_back(wr_op(8'h07, 16'h1111, 2'b11));
        ops.push_back(rd_op(8'h07));
        ops.push_back(wr_op(8'h07, 16'h2222, 2'b11));
        ops.push_back(rd_op(8'h07));
        for (int i = 0; i < 4; i++) ops.push_back(idle_op());
        foreach (ops[i]) begin
            step(ops[i]);
            if (i == 3) begin
                total++; if (dvalid_w[2] !== 1'b1 || do_w[2] !== 16'h1111) begin
                    bad++; $display("FAIL hazard old data lat3: got v=%b %h want v=1 1111", dvalid_w[2], do_w[2]);
                end
            end
            total++; if (dvalid_w !== exp_dv) begin bad++; $display("FAIL hazard dvalid %0d: got %b want %b", i, dvalid_w, exp_dv); end
            for (int g = 0; g < 4; g++) begin
                total++; if (do_w[g] !== exp_do[g]) begin bad++; $display("FAIL hazard do[lat%0d] %0d: got %h want %h", g + 1, i, do_w[g], exp_do[g]); end
            end
        end
        for (int g = 0; g < 4; g++) begin
            total++; if (do_w[g] !== 16'h2222) begin bad++; $display("FAIL hazard new do[lat%0d]: got %h want 2222", g + 1, do_w[g]); end
        end
    endtask

    task automatic test_random();
        op_t o;
        for (int i = 0; i < 400; i++) begin
            o = mk($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
                   8'($urandom_range(0, 15)), 16'($urandom));
            step(o);
            total++; if (ready_w !== {4{m_ready}}) begin bad++; $display("FAIL rand ready %0d: got %b want %b", i, ready_w, {4{m_ready}}); end
            total++; if (dvalid_w !== exp_dv) begin bad++; $display("FAIL rand dvalid %0d: got %b want %b", i, dvalid_w, exp_dv); end
            total++; if (err_w !== {4{exp_err}}) begin bad++; $display("FAIL rand err %0d: got %b want %b", i, err_w, {4{exp_err}}); end
            for (int g = 0; g < 4; g++) begin
                total++; if (do_w[g] !== exp_do[g]) begin bad++; $display("FAIL rand do[lat%0d] %0d: got %h want %h", g + 1, i, do_w[g], exp_do[g]); end
            end
        end
        for (int i = 0; i < 4; i++) step(idle_op());
    endtask

    task automatic test_reset_midflight();
        step(wr_op(8'h10, 16'hBEEF, 2'b11));
        step(rd_op(8'h10));
        step(idle_op());
        NRST = 1'b0;
        model_reset();
        #1;
        total++; if (dvalid_w !== 4'h0) begin bad++; $display("FAIL midreset dvalid: got %b want 0000", dvalid_w); end
        for (int g = 0; g < 4; g++) begin
            total++; if (do_w[g] !== 16'h0) begin bad++; $display("FAIL midreset do[lat%0d]: got %h want 0000", g + 1, do_w[g]); end
        end
        total++; if (ready_w !== 4'h0) begin bad++; $display("FAIL midreset ready: got %b want 0000", ready_w); end
        step(idle_op());
        step(idle_op());
        NRST = 1'b1;
        for (int i = 0; i < 262; i++) begin
            step(i == 256 ? rd_op(8'h10) : idle_op());
            total++; if (ready_w !== {4{m_ready}}) begin bad++; $display("FAIL reinit ready %0d: got %b want %b", i, ready_w, {4{m_ready}}); end
            total++; if (dvalid_w !== exp_dv) begin bad++; $display("FAIL reinit dvalid %0d: got %b want %b", i, dvalid_w, exp_dv); end
            for (int g = 0; g < 4; g++) begin
                total++; if (do_w[g] !== exp_do[g]) begin bad++; $display("FAIL reinit do[lat%0d] %0d: got %h want %h", g + 1, i, do_w[g], exp_do[g]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_byte_enable();
        test_latency();
        test_back_to_back();
        test_illegal();
        test_hazard();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
